layer_result_collector: RTL and testbench

//  Return path of the PU array. Captures the packed outputs of all PU lanes after each

---
 rtl/layer_result_collector_pkg.sv | 14 +
 rtl/result_bank_rf.sv | 30 +++
 rtl/layer_result_collector.sv | 95 +++++++++
 tb/tb_layer_result_collector.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/layer_result_collector_pkg.sv
// Shared defaults for the result-collector slice: PU lane geometry and bank depth.
// NN_LANES / NN_LANE_W match the defaults used by the datapath and PU blocks.
package layer_result_collector_pkg;

  localparam int NN_LANES  = 8;
  localparam int NN_LANE_W = 8;
  localparam int RES_DEPTH = 4;

  // Address width for a bank of n words; never narrower than one bit.
  function automatic int addr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/result_bank_rf.sv
// Two-bank result register file: 2*depth words of size*width bits.
// One synchronous write port and one asynchronous read port.
module result_bank_rf
  import layer_result_collector_pkg::*;
#(
  parameter int size  = NN_LANES,
  parameter int width = NN_LANE_W,
  parameter int depth = RES_DEPTH,
  localparam int aw   = addr_w(depth)
) (
  input  logic                    clk,
  input  logic                    we,
  input  logic                    wbank,
  input  logic [aw-1:0]           waddr,
  input  logic [size*width-1:0]   wdata,
  input  logic                    rbank,
  input  logic [aw-1:0]           raddr,
  output logic [size*width-1:0]   rdata
);

  logic [size*width-1:0] mem [2*depth];

  // NOTE: storage arrays carry no reset; valid-tracking counters decide which words are live.
  always_ff @(posedge clk) begin
    if (we) mem[{wbank, waddr}] <= wdata;
  end

  assign rdata = mem[{rbank, raddr}];

endmodule

// File: rtl/layer_result_collector.sv
// Ping-pong result buffer on the PU return path: collects one layer of lane outputs
// while the previous layer is replayed as the puin stream for the next layer.
module layer_result_collector
  import layer_result_collector_pkg::*;
#(
  parameter int size  = NN_LANES,
  parameter int width = NN_LANE_W,
  parameter int depth = RES_DEPTH
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [size*width-1:0]   puout,
  input  logic                    capture,
  input  logic                    layerdone,
  output logic [size*width-1:0]   puin,
  output logic                    puin_valid,
  input  logic                    puin_ready,
  output logic                    puin_last,
  output logic                    full,
  output logic                    overflow
);

  localparam int cw = $clog2(depth + 1);
  localparam int aw = addr_w(depth);

  logic          wr_bank, rd_bank;
  logic [cw-1:0] wr_cnt, rd_left, eff_cnt;
  logic [aw-1:0] rd_ptr;
  logic          swap_pending;

  logic                  xfer, cap_ok, req_new, rd_free, swap, ovf_set;
  logic [size*width-1:0] rdata;

  always_comb begin
    xfer    = puin_valid & puin_ready;
    // The write bank freezes while a swap is waiting for the reader.
    cap_ok  = capture & (wr_cnt < cw'(depth)) & ~swap_pending;
    eff_cnt = wr_cnt + cw'(cap_ok);
    req_new = layerdone & ~swap_pending & (eff_cnt != '0);
    rd_free = (rd_left == '0) | ((rd_left == cw'(1)) & xfer);
    swap    = (req_new | swap_pending) & rd_free;
    ovf_set = (capture & ~cap_ok) | (layerdone & swap_pending);
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_bank      <= 1'b0;
      rd_bank      <= 1'b0;
      wr_cnt       <= '0;
      rd_left      <= '0;
      rd_ptr       <= '0;
      swap_pending <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      if (ovf_set) overflow <= 1'b1;
      if (swap) begin
        rd_bank      <= wr_bank;
        rd_left      <= eff_cnt;
        rd_ptr       <= '0;
        wr_bank      <= ~wr_bank;
        wr_cnt       <= '0;
        swap_pending <= 1'b0;
      end else begin
        if (xfer) begin
          rd_ptr  <= rd_ptr + aw'(1);
          rd_left <= rd_left - cw'(1);
        end
        if (cap_ok)  wr_cnt       <= eff_cnt;
        if (req_new) swap_pending <= 1'b1;
      end
    end
  end

  result_bank_rf #(
    .size  (size),
    .width (width),
    .depth (depth)
  ) u_rf (
    .clk   (clk),
    .we    (cap_ok),
    .wbank (wr_bank),
    .waddr (wr_cnt[aw-1:0]),
    .wdata (puout),
    .rbank (rd_bank),
    .raddr (rd_ptr),
    .rdata (rdata)
  );

  assign puin_valid = (rd_left != '0);
  assign puin       = puin_valid ? rdata : '0;
  assign puin_last  = puin_valid & (rd_left == cw'(1));
  assign full       = (wr_cnt == cw'(depth)) | swap_pending;

endmodule

// File: tb/tb_layer_result_collector.sv
// Self-checking bench for layer_result_collector: a vector table for straight-line
// collect/drain traffic plus hand-written multi-cycle sequences.
module tb_layer_result_collector;

  localparam int W = 64;

  logic         clk = 1'b0;
  logic         rstn;
  logic [W-1:0] puout;
  logic         capture, layerdone, puin_ready;
  logic [W-1:0] puin;
  logic         puin_valid, puin_last, full, overflow;

  int n_pass = 0;
  int n_total = 0;

  layer_result_collector dut (
    .clk        (clk),
    .rstn       (rstn),
    .puout      (puout),
    .capture    (capture),
    .layerdone  (layerdone),
    .puin       (puin),
    .puin_valid (puin_valid),
    .puin_ready (puin_ready),
    .puin_last  (puin_last),
    .full       (full),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic         cap;
    logic         ld;
    logic         rdy;
    logic [7:0]   d;
    logic         e_valid;
    logic [7:0]   e_byte;
    logic         e_last;
    logic         e_full;
    logic         e_ovf;
  } vec_t;

  function automatic logic [W-1:0] rep(input logic [7:0] b);
    return {8{b}};
  endfunction

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
  endtask

  task automatic check_out(input string tag, input logic v, input logic [7:0] b,
                           input logic l, input logic f, input logic o);
    check({tag, ".valid"}, W'(puin_valid), W'(v));
    check({tag, ".puin"}, puin, v ? rep(b) : '0);
    check({tag, ".last"}, W'(puin_last), W'(l));
    check({tag, ".full"}, W'(full), W'(f));
    check({tag, ".overflow"}, W'(overflow), W'(o));
  endtask

  // Apply inputs for one cycle, then step to 1 time unit past the next rising edge.
  task automatic drive(input logic cap, input logic ld, input logic rdy, input logic [7:0] d);
    capture = cap; layerdone = ld; puin_ready = rdy; puout = rep(d);
    @(posedge clk); #1;
    capture = 1'b0; layerdone = 1'b0; puout = '0;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    capture = 1'b0; layerdone = 1'b0; puin_ready = 1'b0; puout = '0;
    repeat (2) @(posedge clk);
    #4 rstn = 1'b1;
    @(posedge clk); #1;
  endtask

  vec_t vt[$];

  initial begin
    rstn = 1'b0;
    capture = 1'b0; layerdone = 1'b0; puin_ready = 1'b0; puout = '0;
    #3;
    check_out("reset", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    do_reset();
    check_out("post_reset", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

    // Rows: cap, ld, rdy, data | outputs seen during that cycle (before its edge).
    // Three words then close; drain 01,02,03 back-to-back with last on 03.
    vt.push_back('{1, 0, 1, 8'h01, 0, 8'h00, 0, 0, 0});
    vt.push_back('{1, 0, 1, 8'h02, 0, 8'h00, 0, 0, 0});
    vt.push_back('{1, 0, 1, 8'h03, 0, 8'h00, 0, 0, 0});
    vt.push_back('{0, 1, 1, 8'h00, 0, 8'h00, 0, 0, 0});
    vt.push_back('{0, 0, 1, 8'h00, 1, 8'h01, 0, 0, 0});
    vt.push_back('{0, 0, 1, 8'h00, 1, 8'h02, 0, 0, 0});
    vt.push_back('{0, 0, 1, 8'h00, 1, 8'h03, 1, 0, 0});
    vt.push_back('{0, 0, 1, 8'h00, 0, 8'h00, 0, 0, 0});
    // Five captures into a 4-deep bank: 5th dropped, overflow sticks, 4 words drain.
    vt.push_back('{1, 0, 1, 8'h11, 0, 8'h00, 0, 0, 0});
    vt.push_back('{1, 0, 1, 8'h12, 0, 8'h00, 0, 0, 0});
    vt.push_back('{1, 0, 1, 8'h13, 0, 8'h00, 0, 0, 0});
    vt.push_back('{1, 0, 1, 8'h14, 0, 8'h00, 0, 0, 0});
    vt.push_back('{1, 0, 1, 8'h15, 0, 8'h00, 0, 1, 0});
    vt.push_back('{0, 1, 1, 8'h00, 0, 8'h00, 0, 1, 1});
    vt.push_back('{0, 0, 1, 8'h00, 1, 8'h11, 0, 0, 1});
    vt.push_back('{0, 0, 1, 8'h00, 1, 8'h12, 0, 0, 1});
    vt.push_back('{0, 0, 1, 8'h00, 1, 8'h13, 0, 0, 1});
    vt.push_back('{0, 0, 1, 8'h00, 1, 8'h14, 1, 0, 1});
    vt.push_back('{0, 0, 1, 8'h00, 0, 8'h00, 0, 0, 1});

    for (int i = 0; i < vt.size(); i++) begin
      capture = vt[i].cap; layerdone = vt[i].ld; puin_ready = vt[i].rdy; puout = rep(vt[i].d);
      check_out($sformatf("vec%0d", i), vt[i].e_valid, vt[i].e_byte, vt[i].e_last,
                vt[i].e_full, vt[i].e_ovf);
      @(posedge clk); #1;
    end

    // Clear sticky overflow before the remaining sequences.
    do_reset();
    check_out("reset2", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

    // Capture and layerdone on the same edge: that word belongs to the closing layer.
    drive(1, 0, 1, 8'h21);
    drive(1, 1, 1, 8'h22);
    check_out("same_cycle.w0", 1'b1, 8'h21, 1'b0, 1'b0, 1'b0);
    drive(0, 0, 1, 8'h00);
    check_out("same_cycle.w1", 1'b1, 8'h22, 1'b1, 1'b0, 1'b0);
    drive(0, 0, 1, 8'h00);
    check_out("same_cycle.end", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

    // Close with nothing collected: ignored.
    drive(0, 1, 1, 8'h00);
    check_out("empty_close.a", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    drive(0, 0, 1, 8'h00);
    check_out("empty_close.b", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

    // Layer L held with ready=0 while L+1 is collected and closed -> pending swap.
    drive(1, 0, 0, 8'h31);
    drive(1, 0, 0, 8'h32);
    drive(0, 1, 0, 8'h00);
    check_out("hold.l0", 1'b1, 8'h31, 1'b0, 1'b0, 1'b0);
    drive(0, 0, 0, 8'h00);
    check_out("hold.stable", 1'b1, 8'h31, 1'b0, 1'b0, 1'b0);
    drive(1, 0, 0, 8'h41);
    drive(1, 0, 0, 8'h42);
    drive(0, 1, 0, 8'h00);
    check_out("hold.pending", 1'b1, 8'h31, 1'b0, 1'b1, 1'b0);
    drive(0, 0, 1, 8'h00);
    check_out("hold.l1", 1'b1, 8'h32, 1'b1, 1'b1, 1'b0);
    drive(0, 0, 1, 8'h00);
    check_out("hold.next0", 1'b1, 8'h41, 1'b0, 1'b0, 1'b0);
    drive(0, 0, 1, 8'h00);
    check_out("hold.next1", 1'b1, 8'h42, 1'b1, 1'b0, 1'b0);
    drive(0, 0, 1, 8'h00);
    check_out("hold.end", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset mid-drain with a full write bank.
    drive(1, 0, 0, 8'h51);
    drive(1, 0, 0, 8'h52);
    drive(0, 1, 0, 8'h00);
    for (int k = 0; k < 4; k++) drive(1, 0, 0, 8'h61 + 8'(k));
    check_out("areset.pre", 1'b1, 8'h51, 1'b0, 1'b1, 1'b0);
    drive(0, 0, 1, 8'h00);
    check_out("areset.mid", 1'b1, 8'h52, 1'b1, 1'b1, 1'b0);
    puin_ready = 1'b0;
    #2 rstn = 1'b0;
    #1;
    check_out("areset.now", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    #2 rstn = 1'b1;
    @(posedge clk); #1;
    check_out("areset.after", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    drive(1, 0, 1, 8'h71);
    drive(0, 1, 1, 8'h00);
    check_out("areset.new", 1'b1, 8'h71, 1'b1, 1'b0, 1'b0);
    drive(0, 0, 1, 8'h00);
    check_out("areset.done", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
